// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, PC-select codes,
// the bubble instruction and the fetch FSM state encoding.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // free to issue
    WAIT  = 2'd1,  // one request outstanding
    DROP  = 2'd2   // outstanding response is stale
  } fetch_state_e;

  // Code 11 is reserved and behaves as sequential, so only 01/10 redirect.
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JUMP);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus. The fetch stage is the master.
interface if_stage_if #(
  parameter int XLEN = pipe_pkg::XLEN
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} skid buffer that catches a fetch response arriving
// while IF/ID cannot take it.
module fetch_skid_buf
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, instr_q;

  // Occupancy: clear beats load beats unload, so a load in the same cycle
  // as an unload leaves the new entry resident.
  always_comb begin
    full_d = full_q;
    if (clear_i)       full_d = 1'b0;
    else if (load_i)   full_d = 1'b1;
    else if (unload_i) full_d = 1'b0;
  end

  // Occupancy flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  // Payload is captured only on a load that is not being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load_i && !clear_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request FSM, stale-response
// dropping after redirects and the IF/ID pipeline register.
// Optional macro IF_STAGE_PERF_CNT_EN adds fetch/drop performance counters.
module if_stage #(
  parameter int              XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(pipe_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_mux_ctrl,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  if_stage_if.master      imem,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [XLEN-1:0] ifid_instr
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  import pipe_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            req, hs;
  logic            rsp, discard;
  logic            direct, buf_load, buf_unload;
  logic            buf_full;
  logic [XLEN-1:0] buf_pc, buf_instr;

  assign redirect = is_redirect(pc_mux_ctrl);
  assign target   = (pc_mux_ctrl == PC_SEL_BRANCH) ? branch_target : jump_target;

  // Fetch FSM next state and request; also classifies any response as
  // accepted (rsp) or stale (discard).
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    rsp     = 1'b0;
    discard = 1'b0;
    case (state_q)
      FETCH: begin
        req = !redirect && !buf_full && !stall;
        if (req && imem.imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect) begin
            discard = 1'b1;
            state_d = FETCH;
          end else begin
            rsp     = 1'b1;
            req     = !buf_full && !stall;
            state_d = (req && imem.imem_ready) ? WAIT : FETCH;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) begin
          discard = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    // No request may be presented while the stage is held in reset.
    if (!rst_n) req = 1'b0;
  end

  assign hs = req && imem.imem_ready;

  // Response routing: straight into IF/ID when it can move, else the skid
  // buffer. Flush keeps the buffer and any outstanding fetch intact.
  always_comb begin
    direct     = rsp && !stall && !flush && !buf_full;
    buf_load   = rsp && !direct;
    buf_unload = buf_full && !redirect && !stall && !flush;
  end

  // PC and pending-request address next state; redirect overrides stall.
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    if (redirect)  pc_d = target;
    else if (hs)   pc_d = pc_q + XLEN'(4);
    if (hs)        pend_d = pc_q;
  end

  // IF/ID next state: buffered entry first, then a fresh response, else a
  // bubble that keeps the last pc.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (redirect || flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (buf_full) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = buf_pc;
        ifid_instr_d = buf_instr;
      end else if (direct) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = pend_q;
        ifid_instr_d = imem.imem_rdata;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // PC, pending address and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (redirect),
    .load_i   (buf_load),
    .unload_i (buf_unload),
    .pc_i     (pend_q),
    .instr_i  (imem.imem_rdata),
    .full_o   (buf_full),
    .pc_o     (buf_pc),
    .instr_o  (buf_instr)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_pc4       = ifid_pc_q + XLEN'(4);
  assign ifid_instr     = ifid_instr_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_drop_q;

  // Accepted-response and discarded-response counters, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (direct || buf_load) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (discard)            perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed vector table covering the
// redirect/stall/flush/wrap corners, an asynchronous reset check, and a
// random-stall streaming run checked against an expected-fetch queue.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_mux_ctrl = 2'b00;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage_if #(.XLEN(32)) imem ();

  if_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_mux_ctrl   (pc_mux_ctrl),
    .flush         (flush),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem          (imem),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc4      (ifid_pc4),
    .ifid_instr    (ifid_instr)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  typedef struct packed {
    logic        rv;    logic [31:0] rd;  logic rdy;  logic st;
    logic [1:0]  ctl;   logic        fl;  logic [31:0] tgt;
    logic        e_req; logic [31:0] e_addr;
    logic        e_v;   logic [31:0] e_pc; logic [31:0] e_ins;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vt[24];
  sb_t  sb[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic rdy,
                              input logic st, input logic [1:0] ctl, input logic fl,
                              input logic [31:0] tgt, input logic e_req,
                              input logic [31:0] e_addr, input logic e_v,
                              input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rdy = rdy; v.st = st; v.ctl = ctl; v.fl = fl; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic        req_s, hs, st_s, pend;
    logic [31:0] addr_s, pend_addr;
    sb_t         e;

    // rv  rd          rdy st ctl    fl  tgt           | req addr          | v  pc            instr
    vt[0]  = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0000_0000, NOP);
    vt[1]  = mk(1, 32'h1111_0000, 1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 32'h1111_0000);
    vt[2]  = mk(1, 32'h2222_0004, 1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004, 32'h2222_0004);
    vt[3]  = mk(1, 32'hDEAD_BEEF, 1, 1, 2'b00, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0004, 32'h2222_0004);
    vt[4]  = mk(0, 32'h0,         1, 1, 2'b00, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0004, 32'h2222_0004);
    vt[5]  = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0008, 32'hDEAD_BEEF);
    vt[6]  = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0000_0008, NOP);
    vt[7]  = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         0, 32'h0000_0010, 0, 32'h0000_0008, NOP);
    vt[8]  = mk(0, 32'h0,         1, 0, 2'b01, 1, 32'h0000_0100, 0, 32'h0000_0010, 0, 32'h0000_0008, NOP);
    vt[9]  = mk(1, 32'hBAD0_BAD0, 1, 0, 2'b00, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h0000_0008, NOP);
    vt[10] = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0000_0008, NOP);
    vt[11] = mk(1, 32'h0100_0100, 1, 0, 2'b10, 0, 32'h0000_2000, 0, 32'h0000_0104, 0, 32'h0000_0008, NOP);
    vt[12] = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_2000, 0, 32'h0000_0008, NOP);
    vt[13] = mk(1, 32'h2000_2000, 0, 0, 2'b00, 0, 32'h0,         1, 32'h0000_2004, 1, 32'h0000_2000, 32'h2000_2000);
    vt[14] = mk(0, 32'h0,         1, 1, 2'b01, 0, 32'h0000_0300, 0, 32'h0000_2004, 0, 32'h0000_2000, NOP);
    vt[15] = mk(0, 32'h0,         1, 0, 2'b11, 0, 32'h0000_0AA0, 1, 32'h0000_0300, 0, 32'h0000_2000, NOP);
    vt[16] = mk(1, 32'h3000_0300, 1, 0, 2'b11, 0, 32'h0000_0AA0, 1, 32'h0000_0304, 1, 32'h0000_0300, 32'h3000_0300);
    vt[17] = mk(0, 32'h0,         1, 0, 2'b00, 1, 32'h0,         0, 32'h0000_0308, 0, 32'h0000_0300, NOP);
    vt[18] = mk(1, 32'h3000_0304, 1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0308, 1, 32'h0000_0304, 32'h3000_0304);
    vt[19] = mk(1, 32'h3000_0308, 1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_030C, 1, 32'h0000_0308, 32'h3000_0308);
    vt[20] = mk(1, 32'h3000_030C, 1, 0, 2'b01, 0, 32'hFFFF_FFFC, 0, 32'h0000_0310, 0, 32'h0000_0308, NOP);
    vt[21] = mk(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0308, NOP);
    vt[22] = mk(1, 32'hFFFF_0FFC, 1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hFFFF_0FFC);
    vt[23] = mk(1, 32'h0000_0ABC, 1, 0, 2'b00, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 32'h0000_0ABC);

    imem.imem_ready  = 1'b1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   {31'b0, imem.imem_req}, 32'd0);
    chk("rst.addr",  imem.imem_addr, 32'h0);
    chk("rst.valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst.pc",    ifid_pc, 32'h0);
    chk("rst.pc4",   ifid_pc4, 32'h4);
    chk("rst.instr", ifid_instr, NOP);
    rst_n = 1'b1;

    // Directed vector table, one clock per entry.
    for (int i = 0; i < 24; i++) begin
      imem.imem_rvalid = vt[i].rv;
      imem.imem_rdata  = vt[i].rd;
      imem.imem_ready  = vt[i].rdy;
      stall            = vt[i].st;
      pc_mux_ctrl      = vt[i].ctl;
      flush            = vt[i].fl;
      branch_target    = vt[i].tgt;
      jump_target      = vt[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d.req", i),  {31'b0, imem.imem_req}, {31'b0, vt[i].e_req});
      chk($sformatf("v%0d.addr", i), imem.imem_addr, vt[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", i), {31'b0, ifid_valid}, {31'b0, vt[i].e_v});
      chk($sformatf("v%0d.pc", i),    ifid_pc, vt[i].e_pc);
      chk($sformatf("v%0d.pc4", i),   ifid_pc4, vt[i].e_pc + 32'd4);
      chk($sformatf("v%0d.instr", i), ifid_instr, vt[i].e_ins);
    end

    // Asynchronous reset mid-cycle while a fetch is outstanding.
    imem.imem_rvalid = 1'b0;
    imem.imem_ready  = 1'b1;
    stall = 1'b0; pc_mux_ctrl = 2'b00; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.req",   {31'b0, imem.imem_req}, 32'd0);
    chk("arst.addr",  imem.imem_addr, 32'h0);
    chk("arst.valid", {31'b0, ifid_valid}, 32'd0);
    chk("arst.pc",    ifid_pc, 32'h0);
    chk("arst.pc4",   ifid_pc4, 32'h4);
    chk("arst.instr", ifid_instr, NOP);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming run: zero-wait responder, random stall/ready after a clean
    // warm-up that must deliver one instruction per cycle.
    pend = 1'b0;
    pend_addr = '0;
    for (int c = 0; c < 400; c++) begin
      imem.imem_rvalid = pend;
      imem.imem_rdata  = pend ? memf(pend_addr) : 32'h0;
      if (c < 8) begin
        stall = 1'b0;
        imem.imem_ready = 1'b1;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
        imem.imem_ready = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);
      hs     = imem.imem_req && imem.imem_ready;
      addr_s = imem.imem_addr;
      req_s  = imem.imem_req;
      st_s   = stall;
      if (hs) sb.push_back({addr_s, memf(addr_s)});
      @(posedge clk);
      #1;
      pend = hs;
      pend_addr = addr_s;
      if (c >= 1 && c < 8) chk($sformatf("rate%0d.valid", c), {31'b0, ifid_valid}, 32'd1);
      if (c < 8) chk($sformatf("rate%0d.req", c), {31'b0, req_s}, 32'd1);
      if (!st_s && ifid_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb.empty: got pc %h with no fetch expected", ifid_pc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb%0d.pc", c),    ifid_pc, e.pc);
          chk($sformatf("sb%0d.instr", c), ifid_instr, e.instr);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC register, issues requests to instruction memory and fills the IF/ID pipeline register.
- Consumes pc_mux_ctrl/flush from the jump/branch PC-select logic and stall from the hazard unit.
- Handles redirects while a fetch is outstanding by discarding stale responses; a one-entry skid buffer absorbs responses that arrive during a stall.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_mux_ctrl  in  2  00 sequential, 01 branch target, 10 jump target, 11 reserved (treated as 00).
- flush  in  1  kill IF/ID contents this cycle.
- branch_target  in  XLEN  redirect address for 01.
- jump_target  in  XLEN  redirect address for 10.
- stall  in  1  hold PC and IF/ID.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ready  in  1  request accepted when imem_req&&imem_ready.
- imem_rvalid  in  1  response valid, at most one outstanding.
- imem_rdata  in  XLEN  fetched instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  XLEN  PC of ifid_instr.
- ifid_pc4  out  XLEN  ifid_pc+4.
- ifid_instr  out  XLEN  instruction or NOP_INSTR.

Behaviour:
- Reset values:
  - pc=RESET_PC; state=FETCH; skid buffer empty.
  - imem_req=0; ifid_valid=0; ifid_pc=0; ifid_pc4=4; ifid_instr=NOP_INSTR.
  - Reset is asynchronous; any outstanding request is forgotten (memory must be reset with the same rst_n).
- redirect = (pc_mux_ctrl==01)||(pc_mux_ctrl==10).
- States: FETCH (may issue), WAIT (one request outstanding), DROP (outstanding response is stale).
- imem_req is asserted when !redirect && !buffer_full && !stall, and either:
  - state==FETCH, or
  - state==WAIT && imem_rvalid (back-to-back issue).
- On handshake: pc_pend<=pc; pc<=pc+4 (mod 2^XLEN, wraps FFFF_FFFC->0); state<=WAIT.
- WAIT && imem_rvalid && no new handshake -> FETCH.
- Response routing in WAIT:
  - If !stall and buffer empty, the response writes IF/ID directly: valid=1, pc=pc_pend, instr=rdata.
  - Otherwise the response goes into the skid buffer.
- IF/ID update when !stall, in priority order:
  - buffer contents (then the buffer empties);
  - else a WAIT-state response;
  - else a bubble (valid=0, instr=NOP_INSTR, pc/pc4 unchanged).
- When stall=1: IF/ID, pc and buffer hold, except a response may fill an empty buffer.
- Redirect (priority over stall):
  - pc<=selected target; IF/ID <- bubble; buffer cleared.
  - WAIT with no imem_rvalid this cycle -> DROP.
  - WAIT with imem_rvalid this cycle -> response discarded, state -> FETCH.
  - No request is issued in the redirect cycle.
- DROP: imem_req=0; imem_rvalid discarded, state -> FETCH. A further redirect in DROP updates pc and stays in DROP.
- flush=1 without redirect: IF/ID <- bubble only; pc, buffer and outstanding fetch are untouched.
- Latency:
  - Zero-wait memory (ready=1, rvalid the cycle after the handshake) gives a sustained rate of one instruction per cycle.
  - The first valid IF/ID appears 2 cycles after reset release.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - perf_fetch_cnt[31:0]: increments on each response written to IF/ID or the buffer.
  - perf_drop_cnt[31:0]: increments on each discarded response, whether from DROP or redirect-coincident.
  - Both counters reset to 0 and wrap.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN;
  - PC_SEL_SEQ=2'b00, PC_SEL_BRANCH=2'b01, PC_SEL_JUMP=2'b10;
  - NOP_INSTR;
  - fetch state enum {FETCH, WAIT, DROP}.
- One sub-module, fetch_skid_buf: the one-entry {pc, instr} buffer with load/unload/clear and full flag.

Test Plan:
- Reset release with ready=1 and 1-cycle rvalid: imem_addr steps 0,4,8; ifid_pc 0,4,8 on consecutive cycles; ifid_valid=1 from cycle 2.
- Branch redirect: pc_mux_ctrl=01, flush=1, branch_target=0x100 while WAIT with no rvalid -> DROP; the next rvalid is discarded; the next imem_addr is 0x100; IF/ID bubble (NOP_INSTR, valid=0).
- Stall while a response arrives: rdata=0xDEADBEEF is buffered and IF/ID holds. On stall release, IF/ID shows 0xDEADBEEF first and no request is issued while the buffer is full.
- Jump redirect coincident with rvalid: pc_mux_ctrl=10, jump_target=0x2000 -> response dropped, state FETCH, next imem_addr=0x2000.
- Redirect with stall=1: redirect wins; pc loads the target and IF/ID is a bubble.
- Wrap and reserved code: start at pc=0xFFFF_FFFC -> next imem_addr=0x0. pc_mux_ctrl=11 -> sequential, no redirect. Asynchronous reset in WAIT -> outputs take reset values immediately.
